// File: rtl/match_pair_queue_pkg.sv
// rtl/match_pair_queue_pkg.sv - shared index-match types and constants (package aim_pkg)
package aim_pkg;

    localparam int LANES  = 32;
    localparam int LANE_W = 5;
    localparam int POS_W  = 9;
    localparam int CNT_W  = 10;

    typedef logic [LANE_W-1:0] lane_idx_t;
    typedef logic [POS_W-1:0]  pos_t;

    typedef struct packed {
        logic [LANES-1:0]   mask;
        pos_t [LANES-1:0]   pos;
        logic               last;
        logic               occ;
    } match_slot_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/match_pair_queue_if.sv
// rtl/match_pair_queue_if.sv - match vector in / pair stream out bundle; o_ovf present with MATCH_PAIR_QUEUE_OVF_CHK_EN
interface match_pair_queue_if;
    import aim_pkg::*;

    logic                   i_strobe;
    logic [LANES-1:0]       i_valid;
    pos_t [LANES-1:0]       i_pos;
    logic                   i_last;
    logic                   o_in_ready;
    logic                   o_pair_valid;
    lane_idx_t              o_lane;
    pos_t                   o_pos;
    logic                   o_last;
    logic                   i_pair_ready;
    logic                   o_done;
    logic [CNT_W-1:0]       o_pair_cnt;
`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
    logic                   o_ovf;

    modport master (
        output i_strobe, i_valid, i_pos, i_last, i_pair_ready,
        input  o_in_ready, o_pair_valid, o_lane, o_pos, o_last, o_done, o_pair_cnt, o_ovf
    );

    modport slave (
        input  i_strobe, i_valid, i_pos, i_last, i_pair_ready,
        output o_in_ready, o_pair_valid, o_lane, o_pos, o_last, o_done, o_pair_cnt, o_ovf
    );
`else
    modport master (
        output i_strobe, i_valid, i_pos, i_last, i_pair_ready,
        input  o_in_ready, o_pair_valid, o_lane, o_pos, o_last, o_done, o_pair_cnt
    );

    modport slave (
        input  i_strobe, i_valid, i_pos, i_last, i_pair_ready,
        output o_in_ready, o_pair_valid, o_lane, o_pos, o_last, o_done, o_pair_cnt
    );
`endif

endinterface

// File: rtl/lsb_prienc.sv
// rtl/lsb_prienc.sv - combinational lowest-set-bit encoder for a lane mask
module lsb_prienc
    import aim_pkg::*;
(
    input  logic [LANES-1:0] mask,
    output lane_idx_t        idx,
    output logic             nz
);

    // Scan from the top so the lowest set lane is the last (winning) assignment.
    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = lane_idx_t'(i);
            end
        end
    end

    assign nz = |mask;

endmodule

// File: rtl/match_pair_queue.sv
// rtl/match_pair_queue.sv - two-slot match vector buffer serialised into (lane, position) pairs; MATCH_PAIR_QUEUE_OVF_CHK_EN adds o_ovf
module match_pair_queue
    import aim_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    match_pair_queue_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    match_slot_t        slot_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic               in_ready_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    drain_state_t       state_q;
    drain_state_t       state_d;

    lane_idx_t          sel_idx;
    logic               sel_nz;
    logic [LANES-1:0]   rd_mask;
    logic [LANES-1:0]   sel_bit;
    logic [LANES-1:0]   mask_left;
    logic               pair_valid;
    logic               hs;
    logic               rel;
    logic               cap;
    logic [1:0]         occ_d;
    logic               rd_ptr_d;

    assign rd_mask   = slot_q[rd_ptr_q].mask;
    assign sel_bit   = {{(LANES-1){1'b0}}, 1'b1} << sel_idx;
    assign mask_left = rd_mask & ~sel_bit;
    assign cap       = bus.i_strobe && in_ready_q;

    lsb_prienc u_lsb_prienc (
        .mask (rd_mask),
        .idx  (sel_idx),
        .nz   (sel_nz)
    );

    // Drain control: pair presentation, slot release and next occupancy/state.
    always_comb begin
        pair_valid = 1'b0;
        hs         = 1'b0;
        rel        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pair_valid = 1'b0;
            end
            ST_DRAIN: begin
                pair_valid = sel_nz;
                hs         = sel_nz && bus.i_pair_ready;
                // An all-zero slot still spends this one DRAIN cycle before release.
                rel        = !sel_nz || (hs && (mask_left == '0));
            end
            default: begin
                pair_valid = 1'b0;
            end
        endcase

        occ_d = {slot_q[1].occ, slot_q[0].occ};
        if (rel) begin
            occ_d[rd_ptr_q] = 1'b0;
        end
        if (cap) begin
            occ_d[wr_ptr_q] = 1'b1;
        end
        rd_ptr_d = rd_ptr_q ^ rel;
        state_d  = occ_d[rd_ptr_d] ? ST_DRAIN : ST_IDLE;
    end

    // Slot storage, pointers, state and input-side readiness.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
        end else begin
            state_q <= state_d;
            if (hs) begin
                slot_q[rd_ptr_q].mask <= mask_left;
            end
            if (rel) begin
                slot_q[rd_ptr_q].occ <= 1'b0;
            end
            // A capture never targets the read slot while it is occupied.
            if (cap) begin
                slot_q[wr_ptr_q] <= match_slot_t'{mask: bus.i_valid, pos: bus.i_pos,
                                                  last: bus.i_last, occ: 1'b1};
            end
            wr_ptr_q   <= wr_ptr_q ^ cap;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= !(occ_d[0] && occ_d[1]);
        end
    end

    // Tile completion pulse and accepted-pair counter; the count stays visible
    // during the done cycle and restarts on the edge that ends it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= rel && slot_q[rd_ptr_q].last;
            if (done_q) begin
                cnt_q <= hs ? CNT_W'(1) : '0;
            end else if (hs && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
    logic ovf_q;

    // Sticky flag for strobes that arrived while both slots were full.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (bus.i_strobe && !in_ready_q) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.o_ovf = ovf_q;
`endif

    assign bus.o_in_ready   = in_ready_q;
    assign bus.o_pair_valid = pair_valid;
    assign bus.o_lane       = pair_valid ? sel_idx : '0;
    assign bus.o_pos        = pair_valid ? slot_q[rd_ptr_q].pos[sel_idx] : '0;
    assign bus.o_last       = pair_valid && slot_q[rd_ptr_q].last && (mask_left == '0);
    assign bus.o_done       = done_q;
    assign bus.o_pair_cnt   = cnt_q;

endmodule

// File: tb/tb_match_pair_queue.sv
// tb/tb_match_pair_queue.sv - directed self-checking bench for match_pair_queue
module tb_match_pair_queue;
    import aim_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    pos_t [LANES-1:0] pos_v;

    match_pair_queue_if bus ();

    match_pair_queue dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.i_strobe = 1'b0;
        bus.i_valid  = '0;
        bus.i_last   = 1'b0;
        pos_v        = '0;
        bus.i_pos    = pos_v;
    endtask

    initial begin
        int  n;
        int  k;
        logic done_seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_pair_ready = 1'b0;
        clear_in();
        tick();
        tick();

        // Reset state
        check("rst_in_ready", bus.o_in_ready, 1);
        check("rst_outs", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_done, bus.o_pair_cnt}, 0);
`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
        check("rst_ovf", bus.o_ovf, 0);
`endif
        rst = 1'b0;
        tick();
        check("idle_after_rst", {bus.o_in_ready, bus.o_pair_valid}, 2'b10);

        // Single vector, lanes 0 and 2, last-flagged
        bus.i_pair_ready = 1'b1;
        pos_v = '0; pos_v[0] = 9'd3; pos_v[2] = 9'd66;
        bus.i_pos = pos_v; bus.i_valid = 32'h0000_0005; bus.i_last = 1'b1; bus.i_strobe = 1'b1;
        tick();
        clear_in();
        check("t1_pair0", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_pair_cnt}, {1'b1, 5'd0, 9'd3, 1'b0, 10'd0});
        tick();
        check("t1_pair1", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_pair_cnt}, {1'b1, 5'd2, 9'd66, 1'b1, 10'd1});
        tick();
        check("t1_done", {bus.o_pair_valid, bus.o_done, bus.o_pair_cnt}, {1'b0, 1'b1, 10'd2});
        tick();
        check("t1_after", {bus.o_done, bus.o_pair_cnt, bus.o_in_ready}, {1'b0, 10'd0, 1'b1});

        // Backpressure: lanes 0 and 31 with consumer stalled for 4 cycles
        bus.i_pair_ready = 1'b0;
        for (int i = 0; i < LANES; i++) pos_v[i] = pos_t'(i + 100);
        bus.i_pos = pos_v; bus.i_valid = 32'h8000_0001; bus.i_last = 1'b1; bus.i_strobe = 1'b1;
        tick();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            check("t2_hold", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last}, {1'b1, 5'd0, 9'd100, 1'b0});
            if (c < 3) tick();
        end
        bus.i_pair_ready = 1'b1;
        check("t2_pair0", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last}, {1'b1, 5'd0, 9'd100, 1'b0});
        tick();
        check("t2_pair31", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_pair_cnt}, {1'b1, 5'd31, 9'd131, 1'b1, 10'd1});
        tick();
        check("t2_done", {bus.o_pair_valid, bus.o_done, bus.o_pair_cnt}, {1'b0, 1'b1, 10'd2});
        tick();

        // Overflow: three full vectors back-to-back, third one dropped
        bus.i_pair_ready = 1'b0;
        for (int i = 0; i < LANES; i++) pos_v[i] = pos_t'(i * 3);
        bus.i_pos = pos_v; bus.i_valid = 32'hFFFF_FFFF; bus.i_last = 1'b0; bus.i_strobe = 1'b1;
        tick();
        check("t3_ready_after1", bus.o_in_ready, 1);
        bus.i_last = 1'b1;
        tick();
        check("t3_ready_after2", bus.o_in_ready, 0);
        tick();
        clear_in();
        check("t3_first", {bus.o_in_ready, bus.o_pair_valid, bus.o_lane, bus.o_pos}, {1'b0, 1'b1, 5'd0, 9'd0});
`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
        check("t3_ovf", bus.o_ovf, 1);
`endif
        bus.i_pair_ready = 1'b1;
        n = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            if (bus.o_done) begin
                done_seen = 1'b1;
                check("t3_done_cnt", {bus.o_pair_valid, bus.o_pair_cnt}, {1'b0, 10'd64});
            end else if (bus.o_pair_valid) begin
                check("t3_pair", {bus.o_lane, bus.o_pos, bus.o_last, bus.o_pair_cnt},
                      {lane_idx_t'(n % 32), pos_t'((n % 32) * 3), (n == 63), 10'(n)});
                n++;
            end
            tick();
        end
        check("t3_npairs", n, 64);
        check("t3_done_seen", done_seen, 1);
        check("t3_no_third", {bus.o_pair_valid, bus.o_in_ready}, 2'b01);

        // Zero-mask last vector
        bus.i_valid = '0; bus.i_last = 1'b1; bus.i_strobe = 1'b1;
        tick();
        clear_in();
        check("t4_c1", {bus.o_pair_valid, bus.o_done}, 2'b00);
        tick();
        check("t4_c2_done", {bus.o_pair_valid, bus.o_done, bus.o_pair_cnt}, {1'b0, 1'b1, 10'd0});
        tick();
        check("t4_c3", bus.o_done, 0);

        // Reset mid-drain after 5 of 32 pairs
        for (int i = 0; i < LANES; i++) pos_v[i] = pos_t'(i * 3);
        bus.i_pos = pos_v; bus.i_valid = 32'hFFFF_FFFF; bus.i_last = 1'b1; bus.i_strobe = 1'b1;
        tick();
        clear_in();
        repeat (5) tick();
        check("t5_before_rst", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_pair_cnt}, {1'b1, 5'd5, 9'd15, 10'd5});
        #2 rst = 1'b1;
        #1;
        check("t5_async", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_done, bus.o_pair_cnt}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_ready", {bus.o_in_ready, bus.o_pair_valid}, 2'b10);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_no_stale", {bus.o_pair_valid, bus.o_done}, 2'b00);
        end
`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
        check("t5_ovf_cleared", bus.o_ovf, 0);
`endif

        // Interleave: four 0x3 vectors strobed every 2 cycles
        bus.i_pair_ready = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            if (t >= 1 && t <= 8) begin
                k = t - 1;
                check("t6_pair", {bus.o_pair_valid, bus.o_lane, bus.o_pos, bus.o_last, bus.o_pair_cnt},
                      {1'b1, lane_idx_t'(k % 2), pos_t'(10 * (k / 2) + 1 + (k % 2)), (k == 7), 10'(k)});
            end
            if (t == 9) check("t6_done", {bus.o_pair_valid, bus.o_done, bus.o_pair_cnt}, {1'b0, 1'b1, 10'd8});
            if (t == 10) check("t6_after", {bus.o_done, bus.o_pair_cnt}, {1'b0, 10'd0});
            if ((t % 2 == 0) && t < 8) begin
                check("t6_in_ready", bus.o_in_ready, 1);
                pos_v = '0;
                pos_v[0] = pos_t'(10 * (t / 2) + 1);
                pos_v[1] = pos_t'(10 * (t / 2) + 2);
                bus.i_pos = pos_v; bus.i_valid = 32'h0000_0003;
                bus.i_last = (t == 6); bus.i_strobe = 1'b1;
            end else begin
                clear_in();
            end
            tick();
        end
`ifdef MATCH_PAIR_QUEUE_OVF_CHK_EN
        check("t6_ovf", bus.o_ovf, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
